// File: rtl/response_block_pe_pkg.sv
// Shared types and constants for the PE-side response block.
// Targets are encoded 0..N_SLAVE-1 for real slaves, and N_SLAVE for the
// local decode-error pseudo-target.
package response_block_pe_pkg;

    localparam int          N_SLAVE_DEF   = 16;
    // Sized to hold N_SLAVE itself, which is the ERR encoding.
    localparam int          SLV_IDX_W     = $clog2(N_SLAVE_DEF + 1);
    localparam logic [31:0] ERR_RDATA_DEF = 32'hBADACCE5;

    // One encoding width is shared by every instance. It holds the ERR code
    // for any N_SLAVE up to 2**SLV_IDX_W - 1.
    typedef logic [SLV_IDX_W-1:0] tgt_t;

    // ERR pseudo-target code for a given slave count.
    function automatic tgt_t err_tgt(input int n_slave);
        return tgt_t'(n_slave);
    endfunction

endpackage

// File: rtl/pe_outstanding_tracker.sv
// In-flight transaction tracker.
// It holds the outstanding count, the target of the last request, and a
// pending flag for the local error response.
// A new request may issue only when the count is below the limit and the
// request goes to the same target as the current outstanding requests.
// Any slave response that is not expected is flagged as spurious.
module pe_outstanding_tracker
    import response_block_pe_pkg::*;
#(
    parameter int N_SLAVE         = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  tgt_t               target,
    input  logic               fire,
    input  logic [N_SLAVE-1:0] r_valid,
    output logic               issue_ok,
    output logic [CNT_W-1:0]   cnt,
    output tgt_t               last_tgt,
    output logic               err_pend,
    output logic               rsp_take,
    output logic               spurious
);

    localparam tgt_t ERR_T = err_tgt(N_SLAVE);

    logic [CNT_W-1:0]   cnt_q;
    tgt_t               last_q;
    logic               pend_q;
    logic               last_real;
    logic               dec;
    logic [N_SLAVE-1:0] expect_mask;

    // Work out which response is expected, which responses are dropped, and
    // whether a new request may issue.
    // Gating with rst_n keeps all outputs quiet while reset is held.
    always_comb begin
        last_real   = (cnt_q != '0) && (last_q != ERR_T);
        expect_mask = '0;
        for (int i = 0; i < N_SLAVE; i++)
            expect_mask[i] = last_real && (last_q == tgt_t'(i));
        rsp_take = |(r_valid & expect_mask);
        spurious = rst_n && |(r_valid & ~expect_mask);
        dec      = rsp_take || pend_q;
        issue_ok = rst_n && (int'(cnt_q) < MAX_OUTSTANDING) &&
                   ((cnt_q == '0) || (target == last_q));
    end

    // Update the count, the last target and the pending error response.
    // A grant and a response in the same cycle leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            last_q <= '0;
            pend_q <= 1'b0;
        end else begin
            if (fire)
                last_q <= target;
            pend_q <= fire && (target == ERR_T);
            if (fire && !dec)
                cnt_q <= cnt_q + CNT_W'(1);
            else if (!fire && dec)
                cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign cnt      = cnt_q;
    assign last_tgt = last_q;
    assign err_pend = pend_q;

endmodule

// File: rtl/response_block_pe_ot.sv
// PE-side response block for the peripheral interconnect.
// It decodes the request address into a one-hot slave request, and it
// answers out-of-range addresses locally with an error response.
// Responses come back in order, and all outstanding requests go to one
// target.
// Optional macro RESP_REG_EN: when defined, the response outputs
// (valid/rdata/opc) are registered.
module response_block_pe_ot
    import response_block_pe_pkg::*;
#(
    parameter int                    N_SLAVE         = 16,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    ID_WIDTH        = 17,
    parameter int                    ID              = 1,
    parameter int                    PE_ROUTING_LSB  = 16,
    parameter int                    PE_ROUTING_MSB  = 19,
    parameter int                    MAX_OUTSTANDING = 4,
    parameter logic [DATA_WIDTH-1:0] ERR_RDATA       = DATA_WIDTH'(ERR_RDATA_DEF)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          data_req_i,
    input  logic [ADDR_WIDTH-1:0]         data_add_i,
    output logic                          data_gnt_o,
    output logic [N_SLAVE-1:0]            data_req_o,
    input  logic [N_SLAVE-1:0]            data_gnt_i,
    output logic [ID_WIDTH-1:0]           data_ID_o,
    input  logic [N_SLAVE-1:0]            data_r_valid_i,
    input  logic [N_SLAVE*DATA_WIDTH-1:0] data_r_rdata_i,
    input  logic [N_SLAVE-1:0]            data_r_opc_i,
    output logic                          data_r_valid_o,
    output logic [DATA_WIDTH-1:0]         data_r_rdata_o,
    output logic                          data_r_opc_o,
    output logic                          spurious_rsp_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

    localparam int   IDX_W = PE_ROUTING_MSB - PE_ROUTING_LSB + 1;
    localparam int   CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam tgt_t ERR_T = err_tgt(N_SLAVE);

    logic [IDX_W-1:0]      idx;
    logic                  is_err;
    tgt_t                  target;
    tgt_t                  last_tgt;
    logic                  issue_ok;
    logic                  err_pend;
    logic                  rsp_take;
    logic [CNT_W-1:0]      cnt;
    logic                  rsp_v;
    logic                  rsp_opc;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  addr_unused;

    assign idx         = data_add_i[PE_ROUTING_MSB:PE_ROUTING_LSB];
    assign addr_unused = ^{data_add_i[ADDR_WIDTH-1:PE_ROUTING_MSB+1],
                           data_add_i[PE_ROUTING_LSB-1:0]};
    assign is_err      = int'(idx) >= N_SLAVE;
    assign target      = is_err ? ERR_T : tgt_t'(idx);
    assign data_ID_o   = ID_WIDTH'(1) << ID;

    // Drive the one-hot slave request for the decoded target.
    // An ERR target never raises a slave request.
    always_comb begin
        data_req_o = '0;
        for (int i = 0; i < N_SLAVE; i++)
            data_req_o[i] = data_req_i && issue_ok && (target == tgt_t'(i));
    end

    // The master is granted locally for ERR, or by the addressed slave.
    assign data_gnt_o = issue_ok &&
                        (is_err ? data_req_i : |(data_gnt_i & data_req_o));

    pe_outstanding_tracker #(
        .N_SLAVE         (N_SLAVE),
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_tracker (
        .clk      (clk),
        .rst_n    (rst_n),
        .target   (target),
        .fire     (data_gnt_o),
        .r_valid  (data_r_valid_i),
        .issue_ok (issue_ok),
        .cnt      (cnt),
        .last_tgt (last_tgt),
        .err_pend (err_pend),
        .rsp_take (rsp_take),
        .spurious (spurious_rsp_o)
    );

    // Select the response: the local error response, or the expected
    // slave's lane.
    // Data and opc are forced to zero when there is no valid response.
    always_comb begin
        rsp_v    = err_pend || rsp_take;
        rsp_data = '0;
        rsp_opc  = 1'b0;
        if (err_pend) begin
            rsp_data = ERR_RDATA;
            rsp_opc  = 1'b1;
        end else if (rsp_take) begin
            for (int i = 0; i < N_SLAVE; i++) begin
                if (last_tgt == tgt_t'(i)) begin
                    rsp_data = data_r_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                    rsp_opc  = data_r_opc_i[i];
                end
            end
        end
    end

`ifdef RESP_REG_EN
    logic                  rsp_v_q;
    logic                  rsp_opc_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;

    // Register the response by one cycle.
    // The count has already been decremented on the input cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_v_q    <= 1'b0;
            rsp_opc_q  <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            rsp_v_q    <= rsp_v;
            rsp_opc_q  <= rsp_opc;
            rsp_data_q <= rsp_data;
        end
    end

    assign data_r_valid_o = rsp_v_q;
    assign data_r_rdata_o = rsp_data_q;
    assign data_r_opc_o   = rsp_opc_q;
`else
    assign data_r_valid_o = rsp_v;
    assign data_r_rdata_o = rsp_data;
    assign data_r_opc_o   = rsp_opc;
`endif

    assign outstanding_o = cnt;

endmodule

// File: tb/tb_response_block_pe_ot.sv
// Directed bench for response_block_pe_ot, built with N_SLAVE=12 so that
// address fields 12..15 decode to the error target.
module tb_response_block_pe_ot;

    localparam int NS = 12;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req = 1'b0;
    logic [31:0]   addr = '0;
    logic          gnt_o;
    logic [NS-1:0] req_o;
    logic [NS-1:0] gnt_i = '0;
    logic [16:0]   id_o;
    logic [NS-1:0] rv_i = '0;
    logic [NS*DW-1:0] rd_i;
    logic [NS-1:0] opc_i = 12'h020;
    logic          rv_o;
    logic [DW-1:0] rd_o;
    logic          opc_o;
    logic          spur_o;
    logic [2:0]    cnt_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    response_block_pe_ot #(.N_SLAVE(NS)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_req_i     (req),
        .data_add_i     (addr),
        .data_gnt_o     (gnt_o),
        .data_req_o     (req_o),
        .data_gnt_i     (gnt_i),
        .data_ID_o      (id_o),
        .data_r_valid_i (rv_i),
        .data_r_rdata_i (rd_i),
        .data_r_opc_i   (opc_i),
        .data_r_valid_o (rv_o),
        .data_r_rdata_o (rd_o),
        .data_r_opc_o   (opc_o),
        .spurious_rsp_o (spur_o),
        .outstanding_o  (cnt_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic          req;
        logic [3:0]    fld;
        logic [NS-1:0] gnt;
        logic [NS-1:0] rv;
        logic          e_gnt;
        logic [NS-1:0] e_req;
        logic          e_v;
        logic [31:0]   e_d;
        logic          e_opc;
        logic          e_spur;
        logic [2:0]    e_cnt;
    } vec_t;

    vec_t tbl[35];

    function automatic vec_t mk(input logic r, input logic [3:0] f, input logic [NS-1:0] g,
                                input logic [NS-1:0] v, input logic eg, input logic [NS-1:0] er,
                                input logic ev, input logic [31:0] ed, input logic eo,
                                input logic es, input logic [2:0] ec);
        vec_t t;
        t.req = r; t.fld = f; t.gnt = g; t.rv = v; t.e_gnt = eg; t.e_req = er;
        t.e_v = ev; t.e_d = ed; t.e_opc = eo; t.e_spur = es; t.e_cnt = ec;
        return t;
    endfunction

    function automatic logic [31:0] lane(input int i);
        return 32'hC0DE0000 + i;
    endfunction

    task automatic set_addr(input logic [3:0] f);
        addr = {12'h000, f, 16'h0000};
    endtask

    logic        p_v;
    logic [31:0] p_d;
    logic        p_o;

    initial begin
        for (int i = 0; i < NS; i++) rd_i[i*DW +: DW] = lane(i);

        //         req fld   gnt      rv       gnt req      v  data           opc spur cnt
        tbl[0]  = mk(0, 4'd0, 12'h000, 12'h000, 0, 12'h000, 0, 32'h0,         0, 0, 0);
        tbl[1]  = mk(1, 4'd5, 12'h020, 12'h000, 1, 12'h020, 0, 32'h0,         0, 0, 0);
        tbl[2]  = mk(1, 4'd5, 12'h020, 12'h000, 1, 12'h020, 0, 32'h0,         0, 0, 1);
        tbl[3]  = mk(1, 4'd5, 12'h020, 12'h000, 1, 12'h020, 0, 32'h0,         0, 0, 2);
        tbl[4]  = mk(1, 4'd5, 12'h020, 12'h000, 1, 12'h020, 0, 32'h0,         0, 0, 3);
        tbl[5]  = mk(1, 4'd5, 12'h020, 12'h000, 0, 12'h000, 0, 32'h0,         0, 0, 4);
        tbl[6]  = mk(1, 4'd5, 12'h020, 12'h020, 0, 12'h000, 1, lane(5),       1, 0, 4);
        tbl[7]  = mk(1, 4'd5, 12'h020, 12'h000, 1, 12'h020, 0, 32'h0,         0, 0, 3);
        tbl[8]  = mk(0, 4'd0, 12'h000, 12'h020, 0, 12'h000, 1, lane(5),       1, 0, 4);
        tbl[9]  = mk(0, 4'd0, 12'h000, 12'h020, 0, 12'h000, 1, lane(5),       1, 0, 3);
        tbl[10] = mk(0, 4'd0, 12'h000, 12'h020, 0, 12'h000, 1, lane(5),       1, 0, 2);
        tbl[11] = mk(0, 4'd0, 12'h000, 12'h020, 0, 12'h000, 1, lane(5),       1, 0, 1);
        tbl[12] = mk(0, 4'd0, 12'h000, 12'h020, 0, 12'h000, 0, 32'h0,         0, 1, 0);
        tbl[13] = mk(1, 4'd2, 12'h004, 12'h000, 1, 12'h004, 0, 32'h0,         0, 0, 0);
        tbl[14] = mk(1, 4'd2, 12'h004, 12'h000, 1, 12'h004, 0, 32'h0,         0, 0, 1);
        tbl[15] = mk(1, 4'd7, 12'h080, 12'h000, 0, 12'h000, 0, 32'h0,         0, 0, 2);
        tbl[16] = mk(1, 4'd7, 12'h080, 12'h200, 0, 12'h000, 0, 32'h0,         0, 1, 2);
        tbl[17] = mk(1, 4'd2, 12'h004, 12'h004, 1, 12'h004, 1, lane(2),       0, 0, 2);
        tbl[18] = mk(1, 4'd7, 12'h080, 12'h004, 0, 12'h000, 1, lane(2),       0, 0, 2);
        tbl[19] = mk(1, 4'd7, 12'h080, 12'h004, 0, 12'h000, 1, lane(2),       0, 0, 1);
        tbl[20] = mk(1, 4'd7, 12'h080, 12'h000, 1, 12'h080, 0, 32'h0,         0, 0, 0);
        tbl[21] = mk(0, 4'd0, 12'h000, 12'h080, 0, 12'h000, 1, lane(7),       0, 0, 1);
        tbl[22] = mk(1, 4'd13,12'h000, 12'h000, 1, 12'h000, 0, 32'h0,         0, 0, 0);
        tbl[23] = mk(0, 4'd0, 12'h000, 12'h000, 0, 12'h000, 1, 32'hBADACCE5,  1, 0, 1);
        tbl[24] = mk(1, 4'd12,12'h000, 12'h000, 1, 12'h000, 0, 32'h0,         0, 0, 0);
        tbl[25] = mk(1, 4'd15,12'h000, 12'h000, 1, 12'h000, 1, 32'hBADACCE5,  1, 0, 1);
        tbl[26] = mk(0, 4'd0, 12'h000, 12'h000, 0, 12'h000, 1, 32'hBADACCE5,  1, 0, 1);
        tbl[27] = mk(0, 4'd0, 12'h000, 12'h000, 0, 12'h000, 0, 32'h0,         0, 0, 0);
        tbl[28] = mk(1, 4'd4, 12'h000, 12'h000, 0, 12'h010, 0, 32'h0,         0, 0, 0);
        tbl[29] = mk(1, 4'd4, 12'h010, 12'h000, 1, 12'h010, 0, 32'h0,         0, 0, 0);
        tbl[30] = mk(0, 4'd0, 12'h000, 12'h010, 0, 12'h000, 1, lane(4),       0, 0, 1);
        tbl[31] = mk(1, 4'd3, 12'h008, 12'h000, 1, 12'h008, 0, 32'h0,         0, 0, 0);
        tbl[32] = mk(1, 4'd14,12'h000, 12'h000, 0, 12'h000, 0, 32'h0,         0, 0, 1);
        tbl[33] = mk(0, 4'd0, 12'h000, 12'h008, 0, 12'h000, 1, lane(3),       0, 0, 1);
        tbl[34] = mk(0, 4'd0, 12'h000, 12'h000, 0, 12'h000, 0, 32'h0,         0, 0, 0);

        // Reset state
        #3;
        chk("rst gnt", 32'(gnt_o), 32'h0);
        chk("rst req", 32'(req_o), 32'h0);
        chk("rst valid", 32'(rv_o), 32'h0);
        chk("rst rdata", rd_o, 32'h0);
        chk("rst opc", 32'(opc_o), 32'h0);
        chk("rst spur", 32'(spur_o), 32'h0);
        chk("rst cnt", 32'(cnt_o), 32'h0);
        chk("rst id", 32'(id_o), 32'h2);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table. With registered responses, each vector's response
        // appears on the following vector.
        p_v = 1'b0; p_d = '0; p_o = 1'b0;
        for (int k = 0; k < 35; k++) begin
            @(negedge clk);
            req = tbl[k].req; set_addr(tbl[k].fld); gnt_i = tbl[k].gnt; rv_i = tbl[k].rv;
            #2;
            chk($sformatf("v%0d gnt", k), 32'(gnt_o), 32'(tbl[k].e_gnt));
            chk($sformatf("v%0d req", k), 32'(req_o), 32'(tbl[k].e_req));
            chk($sformatf("v%0d spur", k), 32'(spur_o), 32'(tbl[k].e_spur));
            chk($sformatf("v%0d cnt", k), 32'(cnt_o), 32'(tbl[k].e_cnt));
`ifdef RESP_REG_EN
            chk($sformatf("v%0d valid", k), 32'(rv_o), 32'(p_v));
            chk($sformatf("v%0d rdata", k), rd_o, p_d);
            chk($sformatf("v%0d opc", k), 32'(opc_o), 32'(p_o));
`else
            chk($sformatf("v%0d valid", k), 32'(rv_o), 32'(tbl[k].e_v));
            chk($sformatf("v%0d rdata", k), rd_o, tbl[k].e_d);
            chk($sformatf("v%0d opc", k), 32'(opc_o), 32'(tbl[k].e_opc));
`endif
            p_v = tbl[k].e_v; p_d = tbl[k].e_d; p_o = tbl[k].e_opc;
        end

        // Single read from slave 3
        @(negedge clk);
        req = 1'b1; set_addr(4'd3); gnt_i = 12'h008; rv_i = '0;
        #2;
        chk("sr req", 32'(req_o), 32'h008);
        chk("sr gnt", 32'(gnt_o), 32'h1);
        @(negedge clk);
        req = 1'b0; gnt_i = '0; rv_i = 12'h008; rd_i[3*DW +: DW] = 32'h12345678;
        #2;
        chk("sr cnt1", 32'(cnt_o), 32'h1);
`ifndef RESP_REG_EN
        chk("sr valid", 32'(rv_o), 32'h1);
        chk("sr rdata", rd_o, 32'h12345678);
`endif
        @(negedge clk);
        rv_i = '0;
        #2;
        chk("sr cnt0", 32'(cnt_o), 32'h0);
`ifdef RESP_REG_EN
        chk("sr valid", 32'(rv_o), 32'h1);
        chk("sr rdata", rd_o, 32'h12345678);
`else
        chk("sr valid off", 32'(rv_o), 32'h0);
`endif
        rd_i[3*DW +: DW] = lane(3);

        // Reset while three requests to slave 6 are in flight
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req = 1'b1; set_addr(4'd6); gnt_i = 12'h040;
        end
        @(negedge clk);
        #2;
        chk("mr cnt3", 32'(cnt_o), 32'h3);
        rst_n = 1'b0;
        #1;
        chk("mr cnt", 32'(cnt_o), 32'h0);
        chk("mr gnt", 32'(gnt_o), 32'h0);
        chk("mr req", 32'(req_o), 32'h0);
        chk("mr valid", 32'(rv_o), 32'h0);
        chk("mr spur", 32'(spur_o), 32'h0);
        @(negedge clk);
        req = 1'b0; gnt_i = '0;
        rst_n = 1'b1;
        @(negedge clk);
        rv_i = 12'h040;
        #2;
        chk("mr late spur", 32'(spur_o), 32'h1);
        chk("mr late valid", 32'(rv_o), 32'h0);
        chk("mr late cnt", 32'(cnt_o), 32'h0);
        @(negedge clk);
        rv_i = '0;
        #2;
        chk("mr after valid", 32'(rv_o), 32'h0);
        chk("mr after spur", 32'(spur_o), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/response_block_pe_ot.md
Name: response_block_pe_ot

Overview:
- Next-generation PE-side response block for the peripheral interconnect.
- Decodes the master request address into one of N_SLAVE request lines.
- Tracks up to MAX_OUTSTANDING in-flight transactions and returns one response stream to the PE.
- Unlike the combinational predecessor, it enforces in-order responses with a same-target rule, answers out-of-range addresses with a local error response, and detects spurious slave responses.

Parameters:
- N_SLAVE, 16, number of slave ports; need not be a power of 2.
- DATA_WIDTH, 32, read-data width.
- ADDR_WIDTH, 32, address width.
- ID_WIDTH, 17, width of the request ID sent to the slaves.
- ID, 1, index of this PE; data_ID_o = one-hot bit ID.
- PE_ROUTING_LSB, 16, lowest address bit of the slave index field.
- PE_ROUTING_MSB, 19, highest address bit of the slave index field.
- MAX_OUTSTANDING, 4, maximum in-flight transactions; must be ≥1.
- ERR_RDATA, 32'hBADACCE5, read data returned on a decode error.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- data_req_i  in  1  master request
- data_add_i  in  ADDR_WIDTH  master address
- data_gnt_o  out  1  grant to master
- data_req_o  out  N_SLAVE  one-hot request to slaves
- data_gnt_i  in  N_SLAVE  per-slave grant
- data_ID_o  out  ID_WIDTH  request ID, constant one-hot bit ID
- data_r_valid_i  in  N_SLAVE  slave response valid
- data_r_rdata_i  in  N_SLAVE×DATA_WIDTH  slave read data
- data_r_opc_i  in  N_SLAVE  slave response error flag
- data_r_valid_o  out  1  response valid to PE
- data_r_rdata_o  out  DATA_WIDTH  response data
- data_r_opc_o  out  1  response error flag
- spurious_rsp_o  out  1  one-cycle pulse on an unexpected response
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current in-flight count

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Flow control: grant-based only; there is no stall variant.
- Decode: idx = data_add_i[PE_ROUTING_MSB:PE_ROUTING_LSB].
  - idx < N_SLAVE → target = idx.
  - idx ≥ N_SLAVE → target = ERR, an internal pseudo-target.
- Issue condition: issue_ok = (cnt < MAX_OUTSTANDING) && (cnt==0 || target==last_tgt).
- Request path (combinational):
  - data_req_o[idx] = data_req_i && issue_ok, for a valid idx only.
  - data_gnt_o = issue_ok && (target==ERR ? data_req_i : data_gnt_i[idx] && data_req_o[idx]).
  - A request failing issue_ok is held off: no req_o, no gnt_o. The master keeps req asserted.
- On a granted request: last_tgt <= target; cnt increments.
- ERR target: the request is granted without any slave request. The error response fires the cycle after the grant: valid=1, rdata=ERR_RDATA, opc=1.
  - Back-to-back ERR requests each produce one error response, one per cycle, in order.
- Response path:
  - When cnt>0 and last_tgt is a real slave, the output mirrors data_r_*_i[last_tgt] combinationally.
  - Each valid response decrements cnt.
- Spurious responses: a valid on any slave other than last_tgt, or any valid while cnt==0, is dropped. It pulses spurious_rsp_o the same cycle and cnt is unchanged.
- Simultaneous grant and response: cnt unchanged; last_tgt updates (same target by rule).
- Counter bounds: cnt saturates at MAX_OUTSTANDING, enforced by issue_ok. cnt never underflows because spurious responses are ignored.
- Reset values: cnt=0, last_tgt=0, error-response pending flag=0. All outputs are 0 except data_ID_o, which is constant.
- Reset mid-transaction: state clears. Responses arriving later are treated as spurious.
- Latency: request is combinational. Response is 0 cycles for slaves (1 with the option below) and 1 cycle for ERR.

Optional Feature:
- Macro: RESP_REG_EN.
- Defined: data_r_valid_o, data_r_rdata_o and data_r_opc_o are registered, adding 1 cycle for slave responses and 1 cycle for ERR (2 total).
  - cnt still decrements on the input response cycle.
  - spurious_rsp_o stays combinational.
- Undefined: slave responses pass through combinationally.

Decomposition:
- Package response_block_pe_pkg holds:
  - SLV_IDX_W = $clog2(N_SLAVE+1), sized to encode ERR.
  - ERR target encoding = N_SLAVE.
  - Default ERR_RDATA constant.
  - Typedef tgt_t.
- Sub-module pe_outstanding_tracker contains cnt, last_tgt, issue_ok, the ERR pending flag and spurious detection.
- Decode and response muxing stay in the top module.

Test Plan:
- Single read: addr field=3, gnt_i[3]=1 → req_o=16'h0008 and gnt_o=1 same cycle, outstanding_o=1. Then r_valid_i[3] with rdata 0x12345678 → output 0x12345678, outstanding_o=0.
- Depth limit: 4 granted reads to slave 5 with no responses → 5th request gets req_o=0, gnt_o=0. One response → the 5th is granted the next cycle.
- Target switch: 2 outstanding to slave 2, then a request to slave 7 → held until both responses return, then granted.
- Decode error with N_SLAVE=12: address field=13 → gnt_o=1, req_o=0. Next cycle: valid=1, rdata=0xBADACCE5, opc=1.
- Spurious and simultaneous events: r_valid_i[9] while last_tgt=2 → spurious_rsp_o=1, outputs 0, count unchanged. Grant and response to slave 2 in the same cycle → outstanding_o unchanged.
- Reset mid-operation: rst_n low with cnt=3 → all outputs 0 and outstanding_o=0 immediately. A slave response after release → spurious_rsp_o=1. Repeat the single-read case with RESP_REG_EN defined → response appears one cycle later.
